// File: rtl/sa_pkg.sv
// Shared types and constants for the 2x2 output-stationary systolic multiplier.
package sa_pkg;

  localparam int DW_DEFAULT = 4;
  localparam int CW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [3:0] C00 = 4'd0;
  localparam logic [3:0] C01 = 4'd1;
  localparam logic [3:0] C10 = 4'd2;
  localparam logic [3:0] C11 = 4'd3;

  function automatic int sat_limit(input int cw);
    return (1 << cw) - 1;
  endfunction

  localparam int SAT_MAX = sat_limit(CW_DEFAULT);

endpackage

// File: rtl/sa_pe.sv
// Processing element: valid-gated MAC plus registered right/down operand forwarding.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            a_vld,
  input  logic [DW-1:0]   a,
  input  logic            b_vld,
  input  logic [DW-1:0]   b,
  output logic            a_fwd_vld,
  output logic [DW-1:0]   a_fwd,
  output logic            b_fwd_vld,
  output logic [DW-1:0]   b_fwd,
  output logic [2*DW:0]   acc_next
);

  logic [2*DW:0]   acc;
  logic [2*DW-1:0] prod;
  logic            mac;

  assign mac      = a_vld & b_vld;
  assign prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  // acc_next is exported so the bank can capture the final product on the same edge it lands.
  assign acc_next = mac ? acc + {1'b0, prod} : acc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      a_fwd     <= '0;
      a_fwd_vld <= 1'b0;
      b_fwd     <= '0;
      b_fwd_vld <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      a_fwd     <= '0;
      a_fwd_vld <= 1'b0;
      b_fwd     <= '0;
      b_fwd_vld <= 1'b0;
    end else begin
      acc       <= acc_next;
      a_fwd     <= a;
      a_fwd_vld <= a_vld;
      b_fwd     <= b;
      b_fwd_vld <= b_vld;
    end
  end

endmodule

// File: rtl/sa2x2_matmul.sv
// 2x2 systolic matrix multiplier: FSM, skewed operand feed, saturating result bank, read mux.
module sa2x2_matmul
  import sa_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4*DW-1:0] a_in,
  input  logic [4*DW-1:0] b_in,
  input  logic [3:0]      c_select,
  output logic [CW-1:0]   c,
  output logic            busy,
  output logic            done_o
);

  localparam int ACCW = 2*DW + 1;
  localparam logic [ACCW-1:0] SAT_LIM = ACCW'(sat_limit(CW));

  function automatic logic [CW-1:0] saturate(input logic [ACCW-1:0] v);
    return (v > SAT_LIM) ? CW'(SAT_LIM) : CW'(v);
  endfunction

  state_e            state;
  logic [1:0]        cnt;
  logic [4*DW-1:0]   a_q, b_q;
  logic [CW-1:0]     bank [4];
  logic [ACCW-1:0]   acc_next [4];
  logic              launch, last;

  // DONE also accepts start so a held start yields one result every five cycles.
  assign launch = start && (state == IDLE || state == DONE);
  assign last   = (state == COMPUTE) && (cnt == 2'd3);
  assign busy   = (state == COMPUTE);
  assign done_o = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      if (launch) begin
        state <= COMPUTE;
        cnt   <= 2'd0;
        a_q   <= a_in;
        b_q   <= b_in;
      end else if (state == COMPUTE) begin
        cnt <= cnt + 2'd1;
        if (last) state <= DONE;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Skewed edge feed: row/col 0 active on cnt 0..1, row/col 1 on cnt 1..2.
  logic          vld_0, vld_1;
  logic [DW-1:0] row0_a, row1_a, col0_b, col1_b;

  assign vld_0  = busy && (cnt <= 2'd1);
  assign vld_1  = busy && (cnt == 2'd1 || cnt == 2'd2);
  assign row0_a = (cnt == 2'd0) ? a_q[DW-1:0]      : a_q[2*DW-1:DW];
  assign row1_a = (cnt == 2'd1) ? a_q[3*DW-1:2*DW] : a_q[4*DW-1:3*DW];
  assign col0_b = (cnt == 2'd0) ? b_q[DW-1:0]      : b_q[3*DW-1:2*DW];
  assign col1_b = (cnt == 2'd1) ? b_q[2*DW-1:DW]   : b_q[4*DW-1:3*DW];

  logic          pe00_av, pe00_bv, pe01_av, pe01_bv, pe10_av, pe10_bv, pe11_av, pe11_bv;
  logic [DW-1:0] pe00_a, pe00_b, pe01_a, pe01_b, pe10_a, pe10_b, pe11_a, pe11_b;
  logic          unused_fwd;

  sa_pe #(.DW(DW)) u_pe00 (
    .clk(clk), .reset(reset), .clr(launch),
    .a_vld(vld_0), .a(row0_a), .b_vld(vld_0), .b(col0_b),
    .a_fwd_vld(pe00_av), .a_fwd(pe00_a), .b_fwd_vld(pe00_bv), .b_fwd(pe00_b),
    .acc_next(acc_next[0])
  );

  sa_pe #(.DW(DW)) u_pe01 (
    .clk(clk), .reset(reset), .clr(launch),
    .a_vld(pe00_av), .a(pe00_a), .b_vld(vld_1), .b(col1_b),
    .a_fwd_vld(pe01_av), .a_fwd(pe01_a), .b_fwd_vld(pe01_bv), .b_fwd(pe01_b),
    .acc_next(acc_next[1])
  );

  sa_pe #(.DW(DW)) u_pe10 (
    .clk(clk), .reset(reset), .clr(launch),
    .a_vld(vld_1), .a(row1_a), .b_vld(pe00_bv), .b(pe00_b),
    .a_fwd_vld(pe10_av), .a_fwd(pe10_a), .b_fwd_vld(pe10_bv), .b_fwd(pe10_b),
    .acc_next(acc_next[2])
  );

  sa_pe #(.DW(DW)) u_pe11 (
    .clk(clk), .reset(reset), .clr(launch),
    .a_vld(pe10_av), .a(pe10_a), .b_vld(pe01_bv), .b(pe01_b),
    .a_fwd_vld(pe11_av), .a_fwd(pe11_a), .b_fwd_vld(pe11_bv), .b_fwd(pe11_b),
    .acc_next(acc_next[3])
  );

  // Forwards leaving the right and bottom edges of the array go nowhere.
  assign unused_fwd = ^{pe01_av, pe01_a, pe10_bv, pe10_b, pe11_av, pe11_a, pe11_bv, pe11_b};

  // NOTE: the bank is only four registers, so it takes the async reset like any other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) bank[i] <= '0;
    end else if (last) begin
      for (int i = 0; i < 4; i++) bank[i] <= saturate(acc_next[i]);
    end
  end

  // NOTE: c gets a default before the case so unlisted selects cannot infer a latch.
  always_comb begin
    c = '0;
    case (c_select)
      C00:     c = bank[0];
      C01:     c = bank[1];
      C10:     c = bank[2];
      C11:     c = bank[3];
      default: c = '0;
    endcase
  end

endmodule
